// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared defaults and request payload type for the writeback arbiter
package wb_pkg;

    localparam int unsigned DefXlen     = 32;
    localparam int unsigned DefRegNum   = 32;
    localparam int unsigned DefRegWidth = $clog2(DefRegNum);
    localparam int unsigned DefNumSrc   = 3;

    typedef struct packed {
        logic [DefRegWidth-1:0] waddr;
        logic [DefXlen-1:0]     wdata;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin arbiter; WB_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
module rr_arbiter #(
    parameter  int unsigned N    = 3,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o
);

`ifdef WB_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest requesting index is the last writer.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o     = '0;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IdxW'(i);
            end
        end
    end
`else
    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_j;
    logic            w_found;

    // Search upward from the pointer, wrapping modulo N.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_j       = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_j = IdxW'((int'(r_ptr) + i) % int'(N));
            if (!w_found && req_i[w_j]) begin
                gnt_o[w_j] = 1'b1;
                gnt_idx_o  = w_j;
                w_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (|req_i) begin
            r_ptr <= (gnt_idx_o == IdxW'(N - 1)) ? '0 : gnt_idx_o + IdxW'(1);
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter into the register-file write port (WB_ARB_FIXED_PRIO_EN: fixed priority)
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned XLEN     = DefXlen,
    parameter int unsigned RegNum   = DefRegNum,
    parameter int unsigned RegWidth = $clog2(RegNum),
    parameter int unsigned NumSrc   = DefNumSrc,
    parameter int unsigned CntWidth = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumSrc-1:0]                src_valid_i,
    output logic [NumSrc-1:0]                src_ready_o,
    input  logic [NumSrc-1:0][RegWidth-1:0]  src_waddr_i,
    input  logic [NumSrc-1:0][XLEN-1:0]      src_wdata_i,
    output logic                             reg_wen_o,
    output logic [RegWidth-1:0]              reg_waddr_o,
    output logic [XLEN-1:0]                  reg_wdata_o,
    output logic [CntWidth-1:0]              wb_cnt_o
);

    localparam int unsigned IdxW = $clog2(NumSrc);

    typedef struct packed {
        logic [RegWidth-1:0] waddr;
        logic [XLEN-1:0]     wdata;
    } req_t;

    logic [NumSrc-1:0]   w_req;
    logic [NumSrc-1:0]   w_gnt;
    logic [IdxW-1:0]     w_idx;
    logic                w_any;
    logic                w_commit;
    req_t                w_sel;

    logic                r_wen;
    logic [RegWidth-1:0] r_waddr;
    logic [XLEN-1:0]     r_wdata;
    logic [CntWidth-1:0] r_cnt;

    // No source may see ready while the write stage is held in reset.
    assign w_req = rst_ni ? src_valid_i : '0;

    rr_arbiter #(
        .N (NumSrc)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (w_req),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_idx)
    );

    assign src_ready_o = w_gnt;
    assign w_any       = |w_req;
    assign w_sel       = '{waddr: src_waddr_i[w_idx], wdata: src_wdata_i[w_idx]};
    // x0 requests are accepted but never reach the register file.
    assign w_commit    = w_any && (w_sel.waddr != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_wen <= w_commit;
            if (w_any) begin
                r_waddr <= w_sel.waddr;
                r_wdata <= w_sel.wdata;
            end
            if (w_commit) begin
                r_cnt <= r_cnt + CntWidth'(1);
            end
        end
    end

    assign reg_wen_o   = r_wen;
    assign reg_waddr_o = r_waddr;
    assign reg_wdata_o = r_wdata;
    assign wb_cnt_o    = r_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter (honours WB_ARB_FIXED_PRIO_EN)
module tb_wb_arbiter;

    localparam int unsigned NumSrc = 3;
    localparam int unsigned RegW   = 5;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CntW   = 4;
`ifdef WB_ARB_FIXED_PRIO_EN
    localparam bit Fixed = 1'b1;
`else
    localparam bit Fixed = 1'b0;
`endif

    logic                          clk_i;
    logic                          rst_ni;
    logic [NumSrc-1:0]             src_valid_i;
    logic [NumSrc-1:0]             src_ready_o;
    logic [NumSrc-1:0][RegW-1:0]   src_waddr_i;
    logic [NumSrc-1:0][XLEN-1:0]   src_wdata_i;
    logic                          reg_wen_o;
    logic [RegW-1:0]               reg_waddr_o;
    logic [XLEN-1:0]               reg_wdata_o;
    logic [CntW-1:0]               wb_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter #(
        .XLEN     (XLEN),
        .RegNum   (32),
        .NumSrc   (NumSrc),
        .CntWidth (CntW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_waddr_i (src_waddr_i),
        .src_wdata_i (src_wdata_i),
        .reg_wen_o   (reg_wen_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o),
        .wb_cnt_o    (wb_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        src_valid_i = '0;
        rst_ni      = 1'b0;
        step();
        rst_ni      = 1'b1;
    endtask

    logic [NumSrc-1:0] exp_rdy;
    logic [NumSrc-1:0] rdy;
    int                src;
    bit                got2;

    initial begin
        src_waddr_i = '{5'd3, 5'd2, 5'd1};
        src_wdata_i = '{32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};

        // Reset held with every source requesting
        rst_ni      = 1'b0;
        src_valid_i = '1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", src_ready_o, 0);
        check("rst_wen",   reg_wen_o, 0);
        check("rst_waddr", reg_waddr_o, 0);
        check("rst_cnt",   wb_cnt_o, 0);
        rst_ni = 1'b1;
        #1;
        check("rst_first_gnt", src_ready_o, 3'b001);
        step();
        check("rst_first_wen",   reg_wen_o, 1);
        check("rst_first_waddr", reg_waddr_o, 1);

        // Single source
        do_reset();
        src_waddr_i[1] = 5'd5;
        src_wdata_i[1] = 32'hDEAD_BEEF;
        src_valid_i    = 3'b010;
        #1;
        check("single_ready", src_ready_o, 3'b010);
        step();
        src_valid_i = '0;
        check("single_wen",   reg_wen_o, 1);
        check("single_waddr", reg_waddr_o, 5);
        check("single_wdata", reg_wdata_o, 32'hDEAD_BEEF);
        check("single_cnt",   wb_cnt_o, 1);
        step();
        check("idle_wen",   reg_wen_o, 0);
        check("idle_waddr", reg_waddr_o, 5);
        check("idle_cnt",   wb_cnt_o, 1);

        // Round-robin with all sources requesting
        do_reset();
        src_waddr_i = '{5'd3, 5'd2, 5'd1};
        src_valid_i = '1;
        for (int k = 0; k < 6; k++) begin
            src = Fixed ? 0 : k % 3;
            exp_rdy = 3'b001 << src;
            #1;
            check($sformatf("rr_gnt%0d", k), src_ready_o, exp_rdy);
            step();
            check($sformatf("rr_wen%0d", k),   reg_wen_o, 1);
            check($sformatf("rr_waddr%0d", k), reg_waddr_o, src + 1);
        end
        src_valid_i = '0;
        check("rr_cnt", wb_cnt_o, 6);

        // x0 write is accepted, dropped, and advances the pointer
        do_reset();
        src_waddr_i    = '{5'd3, 5'd8, 5'd0};
        src_wdata_i[0] = 32'h0000_1234;
        src_valid_i    = 3'b001;
        #1;
        check("x0_ready", src_ready_o, 3'b001);
        step();
        check("x0_wen", reg_wen_o, 0);
        check("x0_cnt", wb_cnt_o, 0);
        src_waddr_i[0] = 5'd7;
        src_valid_i    = 3'b011;
        #1;
        check("x0_follow_gnt", src_ready_o, Fixed ? 3'b001 : 3'b010);
        step();
        src_valid_i = '0;
        check("x0_follow_waddr", reg_waddr_o, Fixed ? 7 : 8);
        check("x0_follow_cnt",   wb_cnt_o, 1);

        // Held request: src2 must be served within three cycles
        do_reset();
        src_waddr_i    = '{5'd9, 5'd2, 5'd1};
        src_wdata_i[2] = 32'hCAFE_F00D;
        src_valid_i    = '1;
        got2           = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            rdy = src_ready_o;
            step();
            if (rdy[2]) begin
                got2 = 1'b1;
                check("held_waddr", reg_waddr_o, 9);
                check("held_wdata", reg_wdata_o, 32'hCAFE_F00D);
            end
            src_valid_i = src_valid_i & ~rdy;
        end
        src_valid_i = '0;
        check("held_served", got2, 1);

        // Counter wraps at 2^CntW
        do_reset();
        src_waddr_i[0] = 5'd4;
        src_valid_i    = 3'b001;
        for (int c = 0; c < 17; c++) begin
            step();
            if (c == 15) check("wrap_zero", wb_cnt_o, 0);
        end
        src_valid_i = '0;
        check("wrap_cnt", wb_cnt_o, 1);

        // Asynchronous reset clears an in-flight write
        src_valid_i = 3'b001;
        step();
        src_valid_i = '0;
        check("inflight_wen", reg_wen_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_wen", reg_wen_o, 0);
        check("async_rst_cnt", wb_cnt_o, 0);
        rst_ni = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter that sits directly upstream of the scalar register file's write port.
- Collects completed results from NumSrc functional units (ALU, MUL/DIV, LSU, ...) over valid/ready handshakes.
- Grants one per cycle by round-robin and registers the winner into a single write-port stage.
- Drops architectural writes to x0 and keeps a running count of committed writes.

Parameters:
- XLEN, 32, data width of a writeback result
- RegNum, 32, number of architectural registers
- RegWidth, $clog2(RegNum), register address width
- NumSrc, 3, number of requesting functional units; legal range 2..8
- CntWidth, 32, width of the committed-write counter

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  asynchronous active-low reset
- src_valid_i  input  [NumSrc-1:0]  per-source result valid
- src_ready_o  output  [NumSrc-1:0]  per-source accept; handshake when valid&ready
- src_waddr_i  input  [NumSrc-1:0][RegWidth-1:0]  destination register per source
- src_wdata_i  input  [NumSrc-1:0][XLEN-1:0]  result data per source
- reg_wen_o  output  1  register-file write enable
- reg_waddr_o  output  RegWidth  register-file write address
- reg_wdata_o  output  XLEN  register-file write data
- wb_cnt_o  output  CntWidth  number of writes committed since reset

Behaviour:
- Reset is asynchronous, active-low on rst_ni; clock is clk_i.
- Reset values: reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0, wb_cnt_o=0, round-robin pointer rr_q=0.

Grant logic:
- At most one bit of src_ready_o is set per cycle.
- The grant goes to the first source with src_valid_i set, searching upward from rr_q with wrap-around modulo NumSrc.
- src_ready_o is combinational from src_valid_i and rr_q. It is never asserted for a source whose valid is low.
- The output stage never stalls, so any valid source is served within NumSrc cycles (starvation-free).

Round-robin pointer:
- On a grant to index k: rr_q <= (k+1) mod NumSrc.
- With no grant, rr_q holds its value.

Source protocol:
- Once src_valid_i[i] is raised, the source holds it high and keeps its payload stable until the handshake completes.
- A source's valid never depends on its ready.

Output stage:
- Latency is exactly 1 cycle. A handshake in cycle N places the waddr/wdata in reg_waddr_o/reg_wdata_o in cycle N+1.
- In cycle N+1, reg_wen_o = 1 if and only if the granted waddr != 0.
- With no grant in cycle N, reg_wen_o=0 in N+1. Address and data hold their previous values.

x0 writes:
- An x0 request is still handshaked (ready asserted) and advances rr_q.
- It produces reg_wen_o=0 and does not increment wb_cnt_o.

Committed-write counter:
- wb_cnt_o increments by 1 in every cycle where reg_wen_o=1.
- It wraps from 2^CntWidth-1 to 0.

Throughput and reset:
- Throughput is one write per cycle.
- Back-to-back writes to the same register from different sources commit in grant order.
- Reset asserted mid-operation clears the output stage immediately (asynchronously). Any in-flight write in the output stage is lost. Sources must reissue after reset.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins. rr_q is removed and the pointer logic is not generated. Starvation of high indices is permitted.
- When undefined: round-robin as specified above.

Decomposition:
- Package wb_pkg holds:
  - wb_req_t, a packed struct {waddr[RegWidth-1:0], wdata[XLEN-1:0]}.
  - Default constants XLEN=32, RegNum=32, NumSrc=3.
- Sub-module rr_arbiter (parameter N) is natural.
  - Inputs: req[N-1:0].
  - Outputs: one-hot gnt[N-1:0], gnt_idx[$clog2(N)-1:0].
  - Owns the pointer register and the WB_ARB_FIXED_PRIO_EN switch.
- wb_arbiter instantiates rr_arbiter and adds the payload mux, output register and counter.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with all valids high. Expect all ready=0, reg_wen_o=0, wb_cnt_o=0. After release, first grant goes to src0.
- Single source: src1 valid, waddr=5, wdata=0xDEADBEEF. Expect ready[1]=1 that cycle, then next cycle reg_wen_o=1, waddr=5, wdata=0xDEADBEEF, wb_cnt_o=1.
- Round-robin: all 3 sources valid continuously for 6 cycles. Expect grant order 0,1,2,0,1,2, one reg_wen_o per cycle, wb_cnt_o=6. With WB_ARB_FIXED_PRIO_EN, expect 0,0,0,0,0,0.
- x0 drop: src0 writes waddr=0, wdata=0x1234. Expect ready[0]=1, next-cycle reg_wen_o=0, wb_cnt_o unchanged, and rr_q advanced so src1 wins a simultaneous follow-up.
- Held request: src2 valid alone, then src0 and src1 also raised with rr_q=0. Expect src2 stable until granted within ≤3 cycles and its payload delivered unchanged.
- Counter wrap: with CntWidth=4, commit 17 writes. Expect wb_cnt_o to read 1.
